// File: rtl/gbp_ftq_pkg.sv
// Shared types for the global-predictor fetch-target queue: core config subset,
// default-config update/entry structs and pointer type.
package gbp_ftq_pkg;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned INSTR_PER_FETCH;
    int unsigned GlobalPredictorIndexBits;
    bit          RVC;
  } ftq_cfg_t;

  localparam ftq_cfg_t FTQ_CFG_DEFAULT = '{
    VLEN: 32, INSTR_PER_FETCH: 2, GlobalPredictorIndexBits: 8, RVC: 1'b1
  };

  localparam int unsigned DEF_VLEN       = FTQ_CFG_DEFAULT.VLEN;
  localparam int unsigned DEF_IPF        = FTQ_CFG_DEFAULT.INSTR_PER_FETCH;
  localparam int unsigned DEF_IDX_BITS   = FTQ_CFG_DEFAULT.GlobalPredictorIndexBits;
  localparam int unsigned DEF_NR_ENTRIES = 8;
  localparam int unsigned DEF_ID_BITS    = $clog2(DEF_NR_ENTRIES);

  typedef struct packed {
    logic                valid;
    logic [DEF_VLEN-1:0] pc;
    logic                taken;
  } ftq_bht_update_t;

  typedef struct packed {
    logic [DEF_VLEN-1:0]     vpc;
    logic [DEF_IDX_BITS-1:0] index;
    logic [DEF_IPF-1:0]      taken;
  } ftq_entry_t;

  // Pointer carries an extra wrap bit above the entry id.
  typedef logic [DEF_ID_BITS:0] ftq_ptr_t;

  function automatic int unsigned ftq_slot_offset(input bit rvc);
    return rvc ? 1 : 2;
  endfunction

endpackage

// File: rtl/gbp_ftq_ptr.sv
// Wrap-bit queue pointer: load beats increment; o_cmp = {wrap bits equal, id bits equal}
// against the peer pointer.
module gbp_ftq_ptr #(
  parameter int unsigned ID_BITS = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_inc,
  input  logic             i_load,
  input  logic [ID_BITS:0] i_load_val,
  input  logic [ID_BITS:0] i_peer,
  output logic [ID_BITS:0] o_ptr,
  output logic [1:0]       o_cmp
);

  logic [ID_BITS:0] r_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_ptr <= '0;
    else if (i_load) r_ptr <= i_load_val;
    else if (i_inc)  r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;
  assign o_cmp = {r_ptr[ID_BITS] == i_peer[ID_BITS],
                  r_ptr[ID_BITS-1:0] == i_peer[ID_BITS-1:0]};

endmodule

// File: rtl/gbp_ftq.sv
// Fetch-target queue replaying the lookup-time predictor index on branch resolve.
// Optional GBP_FTQ_PERF_CNT_EN adds mispredict / full-stall performance counters.
module gbp_ftq
  import gbp_ftq_pkg::*;
#(
  parameter ftq_cfg_t    CVA6Cfg      = FTQ_CFG_DEFAULT,
  parameter type         bht_update_t = ftq_bht_update_t,
  parameter int unsigned NR_ENTRIES   = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       flush_i,
  input  logic                                       enq_valid_i,
  output logic                                       enq_ready_o,
  input  logic [CVA6Cfg.VLEN-1:0]                    enq_vpc_i,
  input  logic [CVA6Cfg.GlobalPredictorIndexBits-1:0] enq_index_i,
  input  logic [CVA6Cfg.INSTR_PER_FETCH-1:0]         enq_taken_i,
  output logic [$clog2(NR_ENTRIES)-1:0]              enq_id_o,
  input  logic                                       res_valid_i,
  input  logic [$clog2(NR_ENTRIES)-1:0]              res_id_i,
  input  bht_update_t                                res_update_i,
  input  logic                                       res_mispredict_i,
  input  logic                                       commit_i,
  output bht_update_t                                bht_update_o,
  output logic [CVA6Cfg.GlobalPredictorIndexBits-1:0] update_index_o,
  output logic                                       pred_taken_o,
  output logic                                       empty_o
`ifdef GBP_FTQ_PERF_CNT_EN
  ,
  output logic [31:0]                                perf_mispredict_cnt_o,
  output logic [31:0]                                perf_full_stall_cnt_o
`endif
);

  localparam int unsigned VLEN    = CVA6Cfg.VLEN;
  localparam int unsigned IPF     = CVA6Cfg.INSTR_PER_FETCH;
  localparam int unsigned IDXW    = CVA6Cfg.GlobalPredictorIndexBits;
  localparam int unsigned ID_BITS = $clog2(NR_ENTRIES);
  localparam int unsigned OFF     = ftq_slot_offset(CVA6Cfg.RVC);
  localparam int unsigned SLOT_W  = (IPF > 1) ? $clog2(IPF) : 1;

  typedef struct packed {
    logic [VLEN-1:0] vpc;
    logic [IDXW-1:0] index;
    logic [IPF-1:0]  taken;
  } entry_t;

  entry_t r_mem [NR_ENTRIES];

  logic [ID_BITS:0]   w_head, w_tail, w_count, w_res_ptr, w_mis_tail, w_tail_ld;
  logic [ID_BITS-1:0] w_off;
  logic [1:0]         w_cmp_h, w_cmp_t;
  logic [SLOT_W-1:0]  w_slot;
  logic w_full, w_empty, w_res_ok, w_mispred, w_enq, w_commit, w_ptk;

  gbp_ftq_ptr #(.ID_BITS(ID_BITS)) u_head (
    .clk_i, .rst_ni,
    .i_inc(w_commit), .i_load(1'b0), .i_load_val('0),
    .i_peer(w_tail), .o_ptr(w_head), .o_cmp(w_cmp_h)
  );

  gbp_ftq_ptr #(.ID_BITS(ID_BITS)) u_tail (
    .clk_i, .rst_ni,
    .i_inc(w_enq), .i_load(flush_i || w_mispred), .i_load_val(w_tail_ld),
    .i_peer(w_head), .o_ptr(w_tail), .o_cmp(w_cmp_t)
  );

  assign w_empty = &w_cmp_h;
  assign w_full  = (w_cmp_t == 2'b01);

  // Distance of the resolved id from head decides membership in [head, tail).
  assign w_count    = w_tail - w_head;
  assign w_off      = res_id_i - w_head[ID_BITS-1:0];
  assign w_res_ptr  = w_head + {1'b0, w_off};
  assign w_mis_tail = w_res_ptr + 1'b1;
  assign w_res_ok   = res_valid_i && ({1'b0, w_off} < w_count) && !flush_i;
  // A mispredict on an id no longer in flight has nothing to truncate.
  assign w_mispred  = w_res_ok && res_mispredict_i;
  assign w_tail_ld  = flush_i ? w_head : w_mis_tail;
  assign w_enq      = enq_valid_i && !w_full && !flush_i && !w_mispred;
  assign w_commit   = commit_i && !w_empty && !flush_i;

  if (IPF > 1) begin : g_slot
    assign w_slot = res_update_i.pc[OFF+SLOT_W-1:OFF];
  end else begin : g_noslot
    assign w_slot = '0;
  end

  assign w_ptk = r_mem[res_id_i].taken[w_slot];

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[w_tail[ID_BITS-1:0]] <= '{vpc: enq_vpc_i, index: enq_index_i, taken: enq_taken_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bht_update_o   <= '0;
      update_index_o <= '0;
      pred_taken_o   <= 1'b0;
    end else begin
      bht_update_o.valid <= 1'b0;
      if (w_res_ok) begin
        bht_update_o       <= res_update_i;
        bht_update_o.valid <= 1'b1;
        update_index_o     <= r_mem[res_id_i].index;
        pred_taken_o       <= w_ptk;
      end
    end
  end

  assign enq_ready_o = !w_full;
  assign enq_id_o    = w_tail[ID_BITS-1:0];
  assign empty_o     = w_empty;

`ifdef GBP_FTQ_PERF_CNT_EN
  logic [31:0] r_mis_cnt, r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mis_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_res_ok && (w_ptk != res_update_i.taken) && (r_mis_cnt != 32'hFFFF_FFFF))
        r_mis_cnt <= r_mis_cnt + 32'd1;
      if (enq_valid_i && w_full)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_mispredict_cnt_o = r_mis_cnt;
  assign perf_full_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gbp_ftq.sv
// Self-checking bench for gbp_ftq: directed scenarios then random traffic against
// a queue-based reference model.
module tb_gbp_ftq;
  import gbp_ftq_pkg::*;

  localparam int N = 8;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    flush_i, enq_valid_i, enq_ready_o;
  logic [DEF_VLEN-1:0]     enq_vpc_i;
  logic [DEF_IDX_BITS-1:0] enq_index_i, update_index_o;
  logic [DEF_IPF-1:0]      enq_taken_i;
  logic [2:0]              enq_id_o, res_id_i;
  logic                    res_valid_i, res_mispredict_i, commit_i, pred_taken_o, empty_o;
  ftq_bht_update_t         res_update_i, bht_update_o;
`ifdef GBP_FTQ_PERF_CNT_EN
  logic [31:0]             perf_mispredict_cnt_o, perf_full_stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  gbp_ftq #(.NR_ENTRIES(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_vpc_i(enq_vpc_i),
    .enq_index_i(enq_index_i), .enq_taken_i(enq_taken_i), .enq_id_o(enq_id_o),
    .res_valid_i(res_valid_i), .res_id_i(res_id_i), .res_update_i(res_update_i),
    .res_mispredict_i(res_mispredict_i), .commit_i(commit_i),
    .bht_update_o(bht_update_o), .update_index_o(update_index_o),
    .pred_taken_o(pred_taken_o), .empty_o(empty_o)
`ifdef GBP_FTQ_PERF_CNT_EN
    , .perf_mispredict_cnt_o(perf_mispredict_cnt_o), .perf_full_stall_cnt_o(perf_full_stall_cnt_o)
`endif
  );

  typedef struct {
    int         id;
    logic [7:0] idx;
    logic [1:0] tk;
  } ment_t;

  ment_t q[$];
  int    hd;
  int    total, bad;
  int    m_mis, m_stall;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle();
    flush_i = 0; enq_valid_i = 0; enq_vpc_i = '0; enq_index_i = '0; enq_taken_i = '0;
    res_valid_i = 0; res_id_i = '0; res_update_i = '0; res_mispredict_i = 0; commit_i = 0;
  endtask

  task automatic do_rst();
    @(negedge clk_i);
    idle();
    rst_ni = 0;
    #2;
    chk("rst_upd_valid", bht_update_o.valid, 0);
    chk("rst_upd_index", update_index_o, 0);
    chk("rst_pred_taken", pred_taken_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", enq_ready_o, 1);
    chk("rst_enq_id", enq_id_o, 0);
`ifdef GBP_FTQ_PERF_CNT_EN
    chk("rst_perf_mis", perf_mispredict_cnt_o, 0);
    chk("rst_perf_stall", perf_full_stall_cnt_o, 0);
`endif
    q.delete(); hd = 0; m_mis = 0; m_stall = 0;
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  // One clock: apply inputs, check pre-edge state, advance model, check registered outputs.
  task automatic cyc(input bit ev, input logic [7:0] idx, input logic [1:0] tk,
                     input bit rv, input int rid, input bit rtk, input bit mis,
                     input bit cm, input bit fl);
    int p, sz;
    bit full, e_v, e_pt;
    logic [7:0]  e_idx;
    logic [31:0] rpc;
    @(negedge clk_i);
    rpc = $urandom;
    flush_i = fl; enq_valid_i = ev; enq_vpc_i = $urandom; enq_index_i = idx; enq_taken_i = tk;
    res_valid_i = rv; res_id_i = rid[2:0]; res_mispredict_i = mis; commit_i = cm;
    res_update_i.valid = 1'($urandom); res_update_i.pc = rpc; res_update_i.taken = rtk;
    #1;
    sz = q.size();
    full = (sz == N);
    chk("enq_ready", enq_ready_o, !full);
    chk("enq_id", enq_id_o, (hd + sz) % N);
    chk("empty", empty_o, sz == 0);
    if (ev && full) m_stall++;
    p = -1;
    foreach (q[i]) if (q[i].id == rid) p = i;
    e_v = 0; e_pt = 0; e_idx = '0;
    if (fl) q.delete();
    else begin
      if (rv && p >= 0) begin
        e_v = 1; e_idx = q[p].idx; e_pt = q[p].tk[rpc[1]];
        if (e_pt != rtk) m_mis++;
      end
      if (rv && mis && p >= 0) begin
        while (q.size() > p + 1) void'(q.pop_back());
      end else if (ev && !full) q.push_back('{id: (hd + sz) % N, idx: idx, tk: tk});
      if (cm && sz > 0) begin
        void'(q.pop_front());
        hd = (hd + 1) % N;
      end
    end
    @(posedge clk_i);
    #1;
    chk("upd_valid", bht_update_o.valid, e_v);
    if (e_v) begin
      chk("upd_index", update_index_o, e_idx);
      chk("pred_taken", pred_taken_o, e_pt);
      chk("upd_pc", bht_update_o.pc, rpc);
      chk("upd_taken", bht_update_o.taken, rtk);
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit rv;
      rv = ($urandom_range(0, 9) < 4);
      cyc($urandom_range(0, 9) < 6, 8'($urandom), 2'($urandom), rv, $urandom_range(0, N - 1),
          1'($urandom), rv && ($urandom_range(0, 9) < 2), $urandom_range(0, 9) < 3,
          $urandom_range(0, 99) < 3);
    end
  endtask

  initial begin
    total = 0; bad = 0; hd = 0; m_mis = 0; m_stall = 0;
    idle();
    do_rst();

    // Fill to full, then a refused ninth offer.
    for (int i = 0; i < N; i++) cyc(1, 8'h10 + 8'(i), 2'($urandom), 0, 0, 0, 0, 0, 0);
    cyc(1, 8'h20, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("full_not_ready", enq_ready_o, 0);
    // Resolve id 3 -> replays index 0x13.
    cyc(0, 0, 0, 1, 3, 1, 0, 0, 0);
    chk("res3_index", update_index_o, 8'h13);

    // Ids 0..5, mispredict id 2, next enqueue is id 3, resolve id 4 out of range.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 8'h30 + 8'(i), 2'($urandom), 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 1, 0, 0);
    cyc(1, 8'h40, 2'b10, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 1, 0, 0, 0);

    // Full + commit + enqueue: commit only; the retry wraps to id 0.
    for (int i = 0; i < 4; i++) cyc(1, 8'h50 + 8'(i), 2'($urandom), 0, 0, 0, 0, 0, 0);
    cyc(1, 8'h60, 2'b11, 0, 0, 0, 0, 1, 0);
    cyc(1, 8'h61, 2'b11, 0, 0, 0, 0, 0, 0);

    // Flush racing resolve and enqueue.
    cyc(1, 8'h70, 2'b11, 1, 2, 1, 0, 0, 1);
    chk("flush_empty", empty_o, 1);

    // Three stored-taken / actual-not-taken resolves.
    for (int i = 0; i < 3; i++) cyc(1, 8'h80 + 8'(i), 2'b11, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, (hd + i) % N, 0, 0, 0, 0);
`ifdef GBP_FTQ_PERF_CNT_EN
    chk("perf_mis_directed", perf_mispredict_cnt_o, m_mis);
    chk("perf_stall_directed", perf_full_stall_cnt_o, m_stall);
`endif

    rand_cycles(400);
    do_rst();
    rand_cycles(200);
`ifdef GBP_FTQ_PERF_CNT_EN
    chk("perf_mis_final", perf_mispredict_cnt_o, m_mis);
    chk("perf_stall_final", perf_full_stall_cnt_o, m_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
